board_cell_ctrl: RTL and testbench

- Consumer side of the mouse/board-coordinate interface.
- Takes the per-cycle board coordinate stream (8'hFF = no click), extracts single click events, and validates each cell against the board state RAM.
- Performs a read-modify-write of the 2-bit cell state, in either ship-placement or attack mode.
- Reports each outcome as a one-cycle result pulse. Sits between the mouse controller and the board memory/game FSM.

---
 rtl/project_cfg_pkg.sv | 27 ++
 rtl/board_cell_ctrl_if.sv | 13 +
 rtl/board_cell_ctrl_click_edge_det.sv | 67 ++++++
 rtl/board_cell_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_board_cell_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/project_cfg_pkg.sv
// Shared board-game configuration: board geometry, cell encoding and result codes
// used by the board cell controller and its neighbours.
package project_cfg_pkg;

    localparam int         GRID_N          = 10;
    localparam int         NUM_SHIP_CELLS  = 20;
    localparam int         DEBOUNCE_CYCLES = 4;
    localparam logic [7:0] COR_NONE        = 8'hFF;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } cell_t;

    typedef enum logic [2:0] {
        R_PLACED   = 3'd0,
        R_REMOVED  = 3'd1,
        R_HIT      = 3'd2,
        R_MISS     = 3'd3,
        R_REJ_OOB  = 3'd4,
        R_REJ_USED = 3'd5,
        R_REJ_FULL = 3'd6
    } res_t;

endpackage

// File: rtl/board_cell_ctrl_if.sv
// Board state RAM port: one synchronous read (1-cycle latency) and one write strobe.
interface board_cell_ctrl_if;

    logic [6:0] rd_addr;
    logic [1:0] rd_data;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [1:0] wr_data;

    modport master (output rd_addr, input rd_data, output wr_en, output wr_addr, output wr_data);
    modport slave  (input rd_addr, output rd_data, input wr_en, input wr_addr, input wr_data);

endinterface

// File: rtl/board_cell_ctrl_click_edge_det.sv
// Turns the per-cycle coordinate stream into single press events.
// BOARD_CLICK_DEBOUNCE_EN adds a stability counter in front of the press detector.
module click_edge_det
    import project_cfg_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = project_cfg_pkg::DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cor_in,
    output logic       evt,
    output logic [7:0] evt_cor
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    logic [7:0] prev_q, prev_d;

    assign prev_d  = cor_in;
    assign evt_cor = cor_in;

    always_ff @(posedge clk) begin
        if (rst) prev_q <= COR_NONE;
        else     prev_q <= prev_d;
    end

`ifdef BOARD_CLICK_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;

    // armed means an idle cycle has been seen since the last accepted press
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        evt     = 1'b0;
        if (cor_in == COR_NONE) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (cor_in != prev_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CW'(DEBOUNCE_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (armed_q && cor_in != COR_NONE && cor_in == prev_q && cnt_q == CW'(DEBOUNCE_CYCLES)) begin
            evt     = 1'b1;
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end
`else
    assign evt = (cor_in != COR_NONE) && (prev_q == COR_NONE);
`endif

endmodule

// File: rtl/board_cell_ctrl.sv
// Board cell controller: validates each click against board RAM and does the
// placement/attack read-modify-write. BOARD_CLICK_DEBOUNCE_EN enables press debouncing.
module board_cell_ctrl
    import project_cfg_pkg::*;
#(
    parameter int GRID_N          = project_cfg_pkg::GRID_N,
    parameter int NUM_SHIP_CELLS  = project_cfg_pkg::NUM_SHIP_CELLS,
    parameter int DEBOUNCE_CYCLES = project_cfg_pkg::DEBOUNCE_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         cor_in,
    input  logic               mode,
    input  logic               en,
    board_cell_ctrl_if.master  ram,
    output logic               busy,
    output logic               res_valid,
    output logic [2:0]         res_code,
    output logic [7:0]         res_cor,
    output logic [4:0]         ships_left,
    output logic               place_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;

    localparam logic [4:0] GRID_L    = 5'(GRID_N);
    localparam logic [4:0] SHIPS_MAX = 5'(NUM_SHIP_CELLS);

    logic       evt;
    logic [7:0] evt_cor;
    logic [3:0] evt_x, evt_y;

    click_edge_det #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_click (
        .clk     (clk),
        .rst     (rst),
        .cor_in  (cor_in),
        .evt     (evt),
        .evt_cor (evt_cor)
    );

    assign evt_x = evt_cor[7:4];
    assign evt_y = evt_cor[3:0];

    logic [2:0] state_q, state_d;
    logic [7:0] cor_q, cor_d;
    logic       mode_q, mode_d;
    cell_t      cell_q, cell_d;
    logic [6:0] rd_addr_q, rd_addr_d;
    logic       wr_en_q, wr_en_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [1:0] wr_data_q, wr_data_d;
    logic       res_valid_q, res_valid_d;
    logic [2:0] res_code_q, res_code_d;
    logic [7:0] res_cor_q, res_cor_d;
    logic [4:0] ships_q, ships_d;
    logic       do_wr;
    cell_t      new_cell;

    always_comb begin
        state_d     = state_q;
        cor_d       = cor_q;
        mode_d      = mode_q;
        cell_d      = cell_q;
        rd_addr_d   = rd_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        res_valid_d = 1'b0;
        res_code_d  = res_code_q;
        res_cor_d   = res_cor_q;
        ships_d     = ships_q;
        do_wr       = 1'b0;
        new_cell    = cell_q;
        unique case (state_q)
            S_IDLE: if (evt && en) begin
                cor_d  = evt_cor;
                mode_d = mode;
                if ({1'b0, evt_x} >= GRID_L || {1'b0, evt_y} >= GRID_L) begin
                    res_valid_d = 1'b1;
                    res_code_d  = R_REJ_OOB;
                    res_cor_d   = evt_cor;
                end else begin
                    rd_addr_d = {3'd0, evt_y} * 7'(GRID_N) + {3'd0, evt_x};
                    state_d   = S_READ;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT: begin
                cell_d  = cell_t'(ram.rd_data);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                res_valid_d = 1'b1;
                res_cor_d   = cor_q;
                state_d     = S_IDLE;
                if (!mode_q) begin
                    unique case (cell_q)
                        EMPTY: if (ships_q != 5'd0) begin
                            new_cell   = SHIP;
                            do_wr      = 1'b1;
                            ships_d    = ships_q - 5'd1;
                            res_code_d = R_PLACED;
                        end else begin
                            res_code_d = R_REJ_FULL;
                        end
                        SHIP: begin
                            new_cell   = EMPTY;
                            do_wr      = 1'b1;
                            if (ships_q != SHIPS_MAX) ships_d = ships_q + 5'd1;
                            res_code_d = R_REMOVED;
                        end
                        default: res_code_d = R_REJ_USED;
                    endcase
                end else begin
                    unique case (cell_q)
                        EMPTY: begin
                            new_cell   = MISS;
                            do_wr      = 1'b1;
                            res_code_d = R_MISS;
                        end
                        SHIP: begin
                            new_cell   = HIT;
                            do_wr      = 1'b1;
                            res_code_d = R_HIT;
                        end
                        default: res_code_d = R_REJ_USED;
                    endcase
                end
                // the result pulse lands in the WRITE cycle, alongside the strobe
                if (do_wr) begin
                    state_d   = S_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = rd_addr_q;
                    wr_data_d = new_cell;
                end
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cor_q       <= COR_NONE;
            mode_q      <= 1'b0;
            cell_q      <= EMPTY;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            res_valid_q <= 1'b0;
            res_code_q  <= '0;
            res_cor_q   <= COR_NONE;
            ships_q     <= SHIPS_MAX;
        end else begin
            state_q     <= state_d;
            cor_q       <= cor_d;
            mode_q      <= mode_d;
            cell_q      <= cell_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            res_valid_q <= res_valid_d;
            res_code_q  <= res_code_d;
            res_cor_q   <= res_cor_d;
            ships_q     <= ships_d;
        end
    end

    assign ram.rd_addr = rd_addr_q;
    assign ram.wr_en   = wr_en_q;
    assign ram.wr_addr = wr_addr_q;
    assign ram.wr_data = wr_data_q;
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = res_valid_q;
    assign res_code    = res_code_q;
    assign res_cor     = res_cor_q;
    assign ships_left  = ships_q;
    assign place_done  = (ships_q == 5'd0);

endmodule

// File: tb/tb_board_cell_ctrl.sv
// Self-checking bench for board_cell_ctrl: table vectors, corner sequences and
// random clicks against a board-level reference model.
module tb_board_cell_ctrl;
    import project_cfg_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cor_in = 8'hFF;
    logic       mode = 1'b0;
    logic       en = 1'b1;
    logic       busy, res_valid, place_done;
    logic [2:0] res_code;
    logic [7:0] res_cor;
    logic [4:0] ships_left;

    board_cell_ctrl_if bus();

    board_cell_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cor_in     (cor_in),
        .mode       (mode),
        .en         (en),
        .ram        (bus),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_code   (res_code),
        .res_cor    (res_cor),
        .ships_left (ships_left),
        .place_done (place_done)
    );

    always #5 clk = ~clk;

    // board RAM: synchronous read, one-cycle latency
    logic [1:0] mem [128];
    logic       mem_clr = 1'b0, poke_en = 1'b0;
    logic [6:0] poke_addr = '0;
    logic [1:0] poke_val = '0;
    always @(posedge clk) begin
        bus.rd_data <= mem[bus.rd_addr];
        if (mem_clr) for (int i = 0; i < 128; i++) mem[i] <= 2'd0;
        else if (poke_en) mem[poke_addr] <= poke_val;
        else if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    end

    int         cyc = 0, res_cnt = 0, wr_cnt = 0, busy_cnt = 0, res_cyc = 0;
    logic [6:0] last_wa = '0;
    logic [1:0] last_wd = '0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (res_valid) begin res_cnt <= res_cnt + 1; res_cyc <= cyc; end
        if (bus.wr_en) begin wr_cnt <= wr_cnt + 1; last_wa <= bus.wr_addr; last_wd <= bus.wr_data; end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // reference model: board contents as cell codes indexed by x + 10*y
    int bd [100];
    int m_ships = 20;

    task automatic click(input logic [7:0] c, input logic m, input int hold, input bit e,
                         input bit use_tbl, input logic [2:0] tbl_code, input string nm);
        int x, y, a, cur, exp_code, exp_lat, exp_wr, exp_wd, r0, w0, b0, ev, g;
        logic [6:0] rd0;
        x = int'(c[7:4]); y = int'(c[3:0]); a = y * 10 + x;
        exp_wr = 0; exp_wd = 0; exp_lat = 4; exp_code = 0;
        if (x >= 10 || y >= 10) begin
            exp_code = 4; exp_lat = 1;
        end else begin
            cur = bd[a];
            if (!m) begin
                if (cur == 0 && m_ships > 0) begin exp_code = 0; exp_wr = 1; exp_wd = 1; end
                else if (cur == 0)           exp_code = 6;
                else if (cur == 1)           begin exp_code = 1; exp_wr = 1; exp_wd = 0; end
                else                         exp_code = 5;
            end else begin
                if (cur == 0)      begin exp_code = 3; exp_wr = 1; exp_wd = 3; end
                else if (cur == 1) begin exp_code = 2; exp_wr = 1; exp_wd = 2; end
                else               exp_code = 5;
            end
        end
        r0 = res_cnt; w0 = wr_cnt; b0 = busy_cnt; rd0 = bus.rd_addr;
        @(posedge clk); #1;
        cor_in = c; mode = m; en = e; ev = cyc;
        repeat (hold) @(posedge clk);
        #1 cor_in = 8'hFF; en = 1'b1;
        if (!e) begin
            repeat (8) @(negedge clk);
            chk({nm, "_dropped_res"}, res_cnt - r0, 0);
            chk({nm, "_dropped_wr"}, wr_cnt - w0, 0);
            return;
        end
        g = 0;
        while (res_cnt == r0 && g < 20) begin @(negedge clk); g++; end
        repeat (2) @(negedge clk);
        chk({nm, "_res_count"}, res_cnt - r0, 1);
        chk({nm, "_code"}, int'(res_code), exp_code);
        if (use_tbl) chk({nm, "_tbl_code"}, int'(res_code), int'(tbl_code));
        chk({nm, "_cor"}, int'(res_cor), int'(c));
        chk({nm, "_latency"}, res_cyc - ev, exp_lat);
        chk({nm, "_wr_count"}, wr_cnt - w0, exp_wr);
        if (exp_wr != 0) begin
            chk({nm, "_wr_addr"}, int'(last_wa), a);
            chk({nm, "_wr_data"}, int'(last_wd), exp_wd);
            bd[a] = exp_wd;
            if (exp_code == 0) m_ships--;
            if (exp_code == 1 && m_ships < 20) m_ships++;
        end
        if (exp_code == 4) begin
            chk({nm, "_oob_busy"}, busy_cnt - b0, 0);
            chk({nm, "_oob_rd_addr"}, int'(bus.rd_addr), int'(rd0));
        end
        chk({nm, "_ships_left"}, int'(ships_left), m_ships);
        chk({nm, "_place_done"}, int'(place_done), int'(m_ships == 0));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_rd_addr"}, int'(bus.rd_addr), 0);
        chk({nm, "_wr_addr"}, int'(bus.wr_addr), 0);
        chk({nm, "_wr_data"}, int'(bus.wr_data), 0);
        chk({nm, "_wr_en"}, int'(bus.wr_en), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_res_valid"}, int'(res_valid), 0);
        chk({nm, "_res_code"}, int'(res_code), 0);
        chk({nm, "_res_cor"}, int'(res_cor), 8'hFF);
        chk({nm, "_ships_left"}, int'(ships_left), 20);
        chk({nm, "_place_done"}, int'(place_done), 0);
    endtask

    typedef struct {
        logic [7:0] cor;
        logic       m;
        logic [2:0] code;
    } vec_t;
    vec_t tbl [12];

    initial begin
        int r0, w0;
        tbl[0]  = '{8'h23, 1'b0, R_REMOVED};
        tbl[1]  = '{8'hA2, 1'b0, R_REJ_OOB};
        tbl[2]  = '{8'h2A, 1'b0, R_REJ_OOB};
        tbl[3]  = '{8'h00, 1'b0, R_PLACED};
        tbl[4]  = '{8'h99, 1'b0, R_PLACED};
        tbl[5]  = '{8'h99, 1'b0, R_REMOVED};
        tbl[6]  = '{8'h00, 1'b1, R_HIT};
        tbl[7]  = '{8'h00, 1'b1, R_REJ_USED};
        tbl[8]  = '{8'h00, 1'b0, R_REJ_USED};
        tbl[9]  = '{8'h55, 1'b1, R_MISS};
        tbl[10] = '{8'h55, 1'b0, R_REJ_USED};
        tbl[11] = '{8'hBB, 1'b1, R_REJ_OOB};
        for (int i = 0; i < 100; i++) bd[i] = 0;

        mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");

        // held press: one event only
        click(8'h23, 1'b0, 10, 1'b1, 1'b1, R_PLACED, "first_place");
        chk("first_place_addr32", int'(last_wa), 32);

        for (int i = 0; i < 12; i++)
            click(tbl[i].cor, tbl[i].m, 1, 1'b1, 1'b1, tbl[i].code, $sformatf("tbl%0d", i));

        // fill the remaining 19 ship cells, then one more must be refused
        for (int y = 1; y <= 2; y++)
            for (int x = 0; x < 10; x++)
                if (!(y == 2 && x == 9))
                    click({4'(x), 4'(y)}, 1'b0, 1, 1'b1, 1'b0, 3'd0, $sformatf("fill_%0d_%0d", x, y));
        click(8'h92, 1'b0, 1, 1'b1, 1'b1, R_REJ_FULL, "full");
        chk("full_place_done", int'(place_done), 1);

        // attack on a preloaded ship at cell 45
        @(posedge clk); #1 poke_en = 1'b1; poke_addr = 7'd45; poke_val = 2'd1;
        @(posedge clk); #1 poke_en = 1'b0;
        bd[45] = 1;
        click(8'h54, 1'b1, 1, 1'b1, 1'b1, R_HIT, "atk_hit");
        chk("atk_hit_addr45", int'(last_wa), 45);
        click(8'h54, 1'b1, 1, 1'b1, 1'b1, R_REJ_USED, "atk_used");
        click(8'h77, 1'b1, 1, 1'b1, 1'b1, R_MISS, "atk_miss");

        // a click landing while busy is dropped
        r0 = res_cnt; w0 = wr_cnt;
        @(posedge clk); #1 cor_in = 8'h88; mode = 1'b1;
        @(posedge clk); #1 cor_in = 8'hFF;
        @(posedge clk); #1 cor_in = 8'h89;
        @(posedge clk); #1 cor_in = 8'hFF;
        repeat (8) @(negedge clk);
        chk("busy_drop_res", res_cnt - r0, 1);
        chk("busy_drop_wr", wr_cnt - w0, 1);
        chk("busy_drop_addr", int'(last_wa), 88);
        bd[88] = 3;

        click(8'h89, 1'b1, 1, 1'b0, 1'b0, 3'd0, "en_low");

        // reset while waiting on RAM data aborts the operation
        r0 = res_cnt; w0 = wr_cnt;
        @(posedge clk); #1 cor_in = 8'h66; mode = 1'b1;
        @(posedge clk); #1 cor_in = 8'hFF;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_abort_res", res_cnt - r0, 0);
        chk("rst_abort_wr", wr_cnt - w0, 0);
        chk_reset_vals("post_rst");
        m_ships = 20;
        click(8'h66, 1'b1, 1, 1'b1, 1'b1, R_MISS, "post_rst_click");

        for (int i = 0; i < 60; i++) begin
            int x, y;
            x = $urandom_range(11, 0);
            y = $urandom_range(11, 0);
            click({4'(x), 4'(y)}, 1'($urandom_range(1, 0)), $urandom_range(4, 1),
                  ($urandom_range(7, 0) != 0), 1'b0, 3'd0, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
